// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: op codes, FSM state encoding and op-class helpers.
package ex_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_NOP    = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD    = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB    = 6'd2;
    localparam logic [OP_W-1:0] OP_SLL    = 6'd3;
    localparam logic [OP_W-1:0] OP_SLT    = 6'd4;
    localparam logic [OP_W-1:0] OP_SLTU   = 6'd5;
    localparam logic [OP_W-1:0] OP_XOR    = 6'd6;
    localparam logic [OP_W-1:0] OP_SRL    = 6'd7;
    localparam logic [OP_W-1:0] OP_SRA    = 6'd8;
    localparam logic [OP_W-1:0] OP_OR     = 6'd9;
    localparam logic [OP_W-1:0] OP_AND    = 6'd10;
    localparam logic [OP_W-1:0] OP_ADDI   = 6'd11;
    localparam logic [OP_W-1:0] OP_SLTI   = 6'd12;
    localparam logic [OP_W-1:0] OP_SLTIU  = 6'd13;
    localparam logic [OP_W-1:0] OP_XORI   = 6'd14;
    localparam logic [OP_W-1:0] OP_ORI    = 6'd15;
    localparam logic [OP_W-1:0] OP_ANDI   = 6'd16;
    localparam logic [OP_W-1:0] OP_SLLI   = 6'd17;
    localparam logic [OP_W-1:0] OP_SRLI   = 6'd18;
    localparam logic [OP_W-1:0] OP_SRAI   = 6'd19;
    localparam logic [OP_W-1:0] OP_LUI    = 6'd20;
    localparam logic [OP_W-1:0] OP_AUIPC  = 6'd21;
    localparam logic [OP_W-1:0] OP_JAL    = 6'd22;
    localparam logic [OP_W-1:0] OP_JALR   = 6'd23;
    localparam logic [OP_W-1:0] OP_BEQ    = 6'd24;
    localparam logic [OP_W-1:0] OP_BNE    = 6'd25;
    localparam logic [OP_W-1:0] OP_BLT    = 6'd26;
    localparam logic [OP_W-1:0] OP_BGE    = 6'd27;
    localparam logic [OP_W-1:0] OP_BLTU   = 6'd28;
    localparam logic [OP_W-1:0] OP_BGEU   = 6'd29;
    localparam logic [OP_W-1:0] OP_LB     = 6'd30;
    localparam logic [OP_W-1:0] OP_LH     = 6'd31;
    localparam logic [OP_W-1:0] OP_LW     = 6'd32;
    localparam logic [OP_W-1:0] OP_LBU    = 6'd33;
    localparam logic [OP_W-1:0] OP_LHU    = 6'd34;
    localparam logic [OP_W-1:0] OP_SB     = 6'd35;
    localparam logic [OP_W-1:0] OP_SH     = 6'd36;
    localparam logic [OP_W-1:0] OP_SW     = 6'd37;
    localparam logic [OP_W-1:0] OP_MUL    = 6'd38;
    localparam logic [OP_W-1:0] OP_MULH   = 6'd39;
    localparam logic [OP_W-1:0] OP_MULHSU = 6'd40;
    localparam logic [OP_W-1:0] OP_MULHU  = 6'd41;
    localparam logic [OP_W-1:0] OP_DIV    = 6'd42;
    localparam logic [OP_W-1:0] OP_DIVU   = 6'd43;
    localparam logic [OP_W-1:0] OP_REM    = 6'd44;
    localparam logic [OP_W-1:0] OP_REMU   = 6'd45;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } ex_fsm_e;

    function automatic logic is_muldiv_op(input logic [OP_W-1:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative multiply/divide: one bit per cycle on operand magnitudes, sign restored at the output.
module ex_muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              abort,
    input  logic [OP_W-1:0]   op,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic              done,
    output logic [XLEN-1:0]   result
);

    localparam int CNT_W = $clog2(XLEN);

    logic              active_q, active_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              div_q, div_d;
    logic              sel_q, sel_d;        // high half for MULH*, remainder for REM*
    logic              neg_q, neg_d;        // negate product / quotient
    logic              rneg_q, rneg_d;      // negate remainder
    logic              zero_q, zero_d;      // divide by zero
    logic [XLEN-1:0]   dividend_q, dividend_d;
    logic [2*XLEN-1:0] acc_q, acc_d;        // product accumulator or partial remainder
    logic [2*XLEN-1:0] mcand_q, mcand_d;    // shifting multiplicand
    logic [XLEN-1:0]   shr_q, shr_d;        // multiplier bits, or dividend shifting into quotient
    logic [XLEN-1:0]   divisor_q, divisor_d;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     trial;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    // Operand decode, magnitude setup and one shift-add / restoring-subtract step per enabled cycle
    always_comb begin
        active_d   = active_q;
        done_d     = done_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        sel_d      = sel_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        zero_d     = zero_q;
        dividend_d = dividend_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        shr_d      = shr_q;
        divisor_d  = divisor_q;

        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_signed & rs1[XLEN-1];
        b_neg    = b_signed & rs2[XLEN-1];
        a_mag    = a_neg ? -rs1 : rs1;
        b_mag    = b_neg ? -rs2 : rs2;

        trial = {acc_q[XLEN-1:0], shr_q[XLEN-1]} - {1'b0, divisor_q};

        if (en) begin
            if (abort) begin
                active_d = 1'b0;
                done_d   = 1'b0;
            end else if (start) begin
                active_d   = 1'b1;
                done_d     = 1'b0;
                cnt_d      = '0;
                div_d      = is_div_op(op);
                sel_d      = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU) ||
                             (op == OP_REM)  || (op == OP_REMU);
                neg_d      = a_neg ^ b_neg;
                rneg_d     = a_neg;
                zero_d     = (rs2 == '0);
                dividend_d = rs1;
                acc_d      = '0;
                mcand_d    = {{XLEN{1'b0}}, a_mag};
                shr_d      = is_div_op(op) ? a_mag : b_mag;
                divisor_d  = b_mag;
            end else if (active_q) begin
                if (div_q) begin
                    acc_d = '0;
                    if (!trial[XLEN]) begin
                        acc_d[XLEN-1:0] = trial[XLEN-1:0];
                        shr_d           = {shr_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d[XLEN-1:0] = {acc_q[XLEN-2:0], shr_q[XLEN-1]};
                        shr_d           = {shr_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    if (shr_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d = mcand_q << 1;
                    shr_d   = shr_q >> 1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
        end
    end

    // Sign fix-up and special cases (divide by zero) applied to the finished magnitudes
    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -shr_q : shr_q;
        rem  = rneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        if (zero_q) begin
            quo = '1;
            rem = dividend_q;
        end
        if (div_q) begin
            result = sel_q ? rem : quo;
        end else begin
            result = sel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
    end

    assign done = done_q;

    // Iteration state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            div_q      <= 1'b0;
            sel_q      <= 1'b0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            zero_q     <= 1'b0;
            dividend_q <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            shr_q      <= '0;
            divisor_q  <= '0;
        end else begin
            active_q   <= active_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            sel_q      <= sel_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            zero_q     <= zero_d;
            dividend_q <= dividend_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            shr_q      <= shr_d;
            divisor_q  <= divisor_d;
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// RV32I/M execute stage: single-cycle ALU, iterative M unit, registered result with valid/ready.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int MULDIV_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_reg1,
    input  logic [XLEN-1:0]   in_reg2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [OP_W-1:0]   in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic [XLEN-1:0]   out_rd_data,
    output logic [XLEN-1:0]   out_mem_addr,
    output logic [XLEN-1:0]   out_st_data,
    output logic              jump_valid,
    output logic [XLEN-1:0]   jump_target,
    output logic              busy
);

    localparam int SH_W = (XLEN == 64) ? 6 : 5;

    ex_fsm_e           state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   st_data_q, st_data_d;
    logic              jump_valid_q, jump_valid_d;
    logic [XLEN-1:0]   jump_target_q, jump_target_d;
    logic [REG_AW-1:0] m_rd_q, m_rd_d;
    logic [OP_W-1:0]   m_op_q, m_op_d;

    logic              accept;
    logic              mdu_start, mdu_abort, mdu_done;
    logic [XLEN-1:0]   mdu_result;

    logic [OP_W-1:0]   alu_op;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_res, alu_mem, alu_st, alu_tgt;
    logic              alu_jmp;
    logic [XLEN-1:0]   sum_ri, pc_imm, pc4;
    logic [SH_W-1:0]   shamt_r, shamt_i;

    assign busy     = (state_q != ST_IDLE);
    assign in_ready = rst_n & rdy & ~flush & ~busy & ~jump_valid_q & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    // Single-cycle result, writeback address and redirect for the op on the inputs
    always_comb begin
        alu_op  = in_op;
        alu_rd  = in_rd;
        alu_res = '0;
        alu_mem = '0;
        alu_st  = '0;
        alu_jmp = 1'b0;
        alu_tgt = '0;
        sum_ri  = in_reg1 + in_imm;
        pc_imm  = in_pc + in_imm;
        pc4     = in_pc + XLEN'(4);
        shamt_r = in_reg2[SH_W-1:0];
        shamt_i = in_imm[SH_W-1:0];
        case (in_op)
            OP_ADD:   alu_res = in_reg1 + in_reg2;
            OP_SUB:   alu_res = in_reg1 - in_reg2;
            OP_SLL:   alu_res = in_reg1 << shamt_r;
            OP_SLT:   alu_res = XLEN'($signed(in_reg1) < $signed(in_reg2));
            OP_SLTU:  alu_res = XLEN'(in_reg1 < in_reg2);
            OP_XOR:   alu_res = in_reg1 ^ in_reg2;
            OP_SRL:   alu_res = in_reg1 >> shamt_r;
            OP_SRA:   alu_res = $signed(in_reg1) >>> shamt_r;
            OP_OR:    alu_res = in_reg1 | in_reg2;
            OP_AND:   alu_res = in_reg1 & in_reg2;
            OP_ADDI:  alu_res = sum_ri;
            OP_SLTI:  alu_res = XLEN'($signed(in_reg1) < $signed(in_imm));
            OP_SLTIU: alu_res = XLEN'(in_reg1 < in_imm);
            OP_XORI:  alu_res = in_reg1 ^ in_imm;
            OP_ORI:   alu_res = in_reg1 | in_imm;
            OP_ANDI:  alu_res = in_reg1 & in_imm;
            OP_SLLI:  alu_res = in_reg1 << shamt_i;
            OP_SRLI:  alu_res = in_reg1 >> shamt_i;
            OP_SRAI:  alu_res = $signed(in_reg1) >>> shamt_i;
            OP_LUI:   alu_res = in_imm;
            OP_AUIPC: alu_res = pc_imm;
            OP_JAL: begin
                alu_res = pc4;
                alu_jmp = 1'b1;
                alu_tgt = pc_imm;
            end
            OP_JALR: begin
                alu_res = pc4;
                alu_jmp = 1'b1;
                alu_tgt = sum_ri & ~XLEN'(1);
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                alu_rd  = '0;
                alu_tgt = pc_imm;
                case (in_op)
                    OP_BEQ:  alu_jmp = (in_reg1 == in_reg2);
                    OP_BNE:  alu_jmp = (in_reg1 != in_reg2);
                    OP_BLT:  alu_jmp = ($signed(in_reg1) <  $signed(in_reg2));
                    OP_BGE:  alu_jmp = ($signed(in_reg1) >= $signed(in_reg2));
                    OP_BLTU: alu_jmp = (in_reg1 <  in_reg2);
                    default: alu_jmp = (in_reg1 >= in_reg2);
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: alu_mem = sum_ri;
            OP_SB, OP_SH, OP_SW: begin
                alu_rd  = '0;
                alu_mem = sum_ri;
                alu_st  = in_reg2;
            end
            default: begin
                // NOP, unknown codes and M ops with the M unit disabled retire as a NOP
                alu_op = OP_NOP;
                alu_rd = '0;
            end
        endcase
    end

    // Result register, redirect pulse and M-unit FSM: flush beats accept beats hold; rdy=0 freezes all
    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_op_d      = out_op_q;
        rd_addr_d     = rd_addr_q;
        rd_data_d     = rd_data_q;
        mem_addr_d    = mem_addr_q;
        st_data_d     = st_data_q;
        jump_valid_d  = jump_valid_q;
        jump_target_d = jump_target_q;
        m_rd_d        = m_rd_q;
        m_op_d        = m_op_q;
        mdu_start     = 1'b0;
        mdu_abort     = 1'b0;
        if (rdy) begin
            jump_valid_d = 1'b0;
            if (flush) begin
                out_valid_d = 1'b0;
                out_op_d    = OP_NOP;
                state_d     = ST_IDLE;
                mdu_abort   = 1'b1;
            end else begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_op_d    = OP_NOP;
                    if (state_q == ST_DONE) begin
                        state_d = ST_IDLE;
                    end
                end
                if (accept) begin
                    if ((MULDIV_EN != 0) && is_muldiv_op(in_op)) begin
                        mdu_start = 1'b1;
                        state_d   = is_div_op(in_op) ? ST_DIV : ST_MUL;
                        m_rd_d    = in_rd;
                        m_op_d    = in_op;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_op_d     = alu_op;
                        rd_addr_d    = alu_rd;
                        rd_data_d    = alu_res;
                        mem_addr_d   = alu_mem;
                        st_data_d    = alu_st;
                        jump_valid_d = alu_jmp;
                        if (alu_jmp) begin
                            jump_target_d = alu_tgt;
                        end
                    end
                end
                if (((state_q == ST_MUL) || (state_q == ST_DIV)) && mdu_done) begin
                    out_valid_d = 1'b1;
                    out_op_d    = m_op_q;
                    rd_addr_d   = m_rd_q;
                    rd_data_d   = mdu_result;
                    mem_addr_d  = '0;
                    st_data_d   = '0;
                    state_d     = ST_DONE;
                end
            end
        end
    end

    // Stage state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            out_valid_q   <= 1'b0;
            out_op_q      <= OP_NOP;
            rd_addr_q     <= '0;
            rd_data_q     <= '0;
            mem_addr_q    <= '0;
            st_data_q     <= '0;
            jump_valid_q  <= 1'b0;
            jump_target_q <= '0;
            m_rd_q        <= '0;
            m_op_q        <= OP_NOP;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_op_q      <= out_op_d;
            rd_addr_q     <= rd_addr_d;
            rd_data_q     <= rd_data_d;
            mem_addr_q    <= mem_addr_d;
            st_data_q     <= st_data_d;
            jump_valid_q  <= jump_valid_d;
            jump_target_q <= jump_target_d;
            m_rd_q        <= m_rd_d;
            m_op_q        <= m_op_d;
        end
    end

    ex_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (rdy),
        .start  (mdu_start),
        .abort  (mdu_abort),
        .op     (in_op),
        .rs1    (in_reg1),
        .rs2    (in_reg2),
        .done   (mdu_done),
        .result (mdu_result)
    );

    assign out_valid    = out_valid_q;
    assign out_op       = out_op_q;
    assign out_rd_addr  = rd_addr_q;
    assign out_rd_data  = rd_data_q;
    assign out_mem_addr = mem_addr_q;
    assign out_st_data  = st_data_q;
    assign jump_valid   = jump_valid_q;
    assign jump_target  = jump_target_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe with hand-computed expectations.
module tb_ex_stage_pipe;
    import ex_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n, rdy, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     in_pc, in_reg1, in_reg2, in_imm;
    logic [4:0]      in_rd;
    logic [OP_W-1:0] in_op, out_op;
    logic [4:0]      out_rd_addr;
    logic [31:0]     out_rd_data, out_mem_addr, out_st_data, jump_target;
    logic            jump_valid, busy;

    int checks   = 0;
    int failures = 0;
    int lat;
    logic seen;

    always #5 clk = ~clk;

    ex_stage_pipe #(.XLEN(32), .REG_AW(5), .MULDIV_EN(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_reg1      (in_reg1),
        .in_reg2      (in_reg2),
        .in_imm       (in_imm),
        .in_rd        (in_rd),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .out_rd_addr  (out_rd_addr),
        .out_rd_data  (out_rd_data),
        .out_mem_addr (out_mem_addr),
        .out_st_data  (out_st_data),
        .jump_valid   (jump_valid),
        .jump_target  (jump_target),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] rd);
        in_op = op; in_pc = pc; in_reg1 = r1; in_reg2 = r2; in_imm = imm; in_rd = rd;
        in_valid = 1'b1;
        #0;
        chk("in_ready_at_issue", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_m(input string tag, input logic [OP_W-1:0] op, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] exp);
        issue(op, 32'h0, r1, r2, 32'h0, 5'd9);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd34);
        chk({tag, "_data"}, 64'(out_rd_data), 64'(exp));
        chk({tag, "_rd"}, 64'(out_rd_addr), 64'd9);
        $display("txn %s op=%0d a=%h b=%h result=%h latency=%0d", tag, op, r1, r2, out_rd_data, lat);
        step();
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic alu(input string tag, input logic [OP_W-1:0] op, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm, input logic [31:0] exp);
        issue(op, 32'h0, r1, r2, imm, 5'd2);
        chk(tag, 64'(out_rd_data), 64'(exp));
        $display("txn %s op=%0d a=%h b=%h imm=%h result=%h", tag, op, r1, r2, imm, out_rd_data);
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_reg1 = '0; in_reg2 = '0; in_imm = '0; in_rd = '0; in_op = OP_NOP;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_op", 64'(out_op), 64'(OP_NOP));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_jump_valid", 64'(jump_valid), 64'd0);
        chk("rst_rd_data", 64'(out_rd_data), 64'd0);
        #10 rst_n = 1'b1;
        step();

        // ADDI 5 + -7
        issue(OP_ADDI, 32'h0, 32'd5, 32'h0, 32'hFFFF_FFF9, 5'd3);
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_data", 64'(out_rd_data), 64'hFFFF_FFFE);
        chk("addi_rd", 64'(out_rd_addr), 64'd3);
        $display("txn addi result=%h", out_rd_data);

        // BEQ taken
        issue(OP_BEQ, 32'h100, 32'd3, 32'd3, 32'h20, 5'd7);
        chk("beq_jump", 64'(jump_valid), 64'd1);
        chk("beq_target", 64'(jump_target), 64'h120);
        chk("beq_in_ready", 64'(in_ready), 64'd0);
        chk("beq_rd", 64'(out_rd_addr), 64'd0);
        $display("txn beq jump=%0b target=%h", jump_valid, jump_target);
        step();
        chk("beq_pulse_end", 64'(jump_valid), 64'd0);

        // BNE not taken
        issue(OP_BNE, 32'h100, 32'd3, 32'd3, 32'h20, 5'd7);
        chk("bne_valid", 64'(out_valid), 64'd1);
        chk("bne_jump", 64'(jump_valid), 64'd0);
        chk("bne_rd", 64'(out_rd_addr), 64'd0);
        $display("txn bne jump=%0b rd=%0d", jump_valid, out_rd_addr);

        // JALR
        issue(OP_JALR, 32'h40, 32'h1001, 32'h0, 32'd2, 5'd1);
        chk("jalr_jump", 64'(jump_valid), 64'd1);
        chk("jalr_target", 64'(jump_target), 64'h1002);
        chk("jalr_link", 64'(out_rd_data), 64'h44);
        $display("txn jalr target=%h link=%h", jump_target, out_rd_data);
        step();

        // Assorted single-cycle ops
        alu("sub",  OP_SUB,  32'd5, 32'd7, 32'h0, 32'hFFFF_FFFE);
        alu("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'h0, 32'd1);
        alu("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd0);
        alu("sra",  OP_SRA,  32'h8000_0000, 32'd4, 32'h0, 32'hF800_0000);
        alu("srl",  OP_SRL,  32'h8000_0000, 32'd4, 32'h0, 32'h0800_0000);
        alu("sll_mask", OP_SLL, 32'd1, 32'h3F, 32'h0, 32'h8000_0000);
        alu("sltiu", OP_SLTIU, 32'd1, 32'h0, 32'hFFFF_FFFF, 32'd1);

        // Store
        issue(OP_SW, 32'h0, 32'h100, 32'hAB, 32'd8, 5'd5);
        chk("sw_addr", 64'(out_mem_addr), 64'h108);
        chk("sw_data", 64'(out_st_data), 64'hAB);
        chk("sw_rd", 64'(out_rd_addr), 64'd0);
        $display("txn sw addr=%h data=%h", out_mem_addr, out_st_data);
        step();

        // Backpressure
        out_ready = 1'b0;
        issue(OP_ADD, 32'h0, 32'd10, 32'd20, 32'h0, 5'd4);
        chk("bp_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_data", 64'(out_rd_data), 64'd30);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        step();
        chk("bp_consumed", 64'(out_valid), 64'd0);
        chk("bp_op_nop", 64'(out_op), 64'(OP_NOP));
        $display("txn add backpressure consumed");

        // rdy=0 freezes
        issue(OP_ADD, 32'h0, 32'd1, 32'd2, 32'h0, 5'd4);
        rdy = 1'b0;
        step();
        step();
        chk("frz_valid", 64'(out_valid), 64'd1);
        chk("frz_in_ready", 64'(in_ready), 64'd0);
        rdy = 1'b1;
        step();
        chk("frz_consumed", 64'(out_valid), 64'd0);
        $display("txn add freeze released");

        // M unit
        run_m("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_m("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_m("divu0",  OP_DIVU,   32'h1234, 32'd0, 32'hFFFF_FFFF);
        run_m("remu0",  OP_REMU,   32'h1234, 32'd0, 32'h1234);
        run_m("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_m("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_m("divu",   OP_DIVU,   32'd100, 32'd7, 32'd14);
        run_m("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_m("mul",    OP_MUL,    32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_m("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_m("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);

        // Flush at cycle 10 of a divide, with an op presented in the flush cycle
        issue(OP_DIV, 32'h0, 32'd100, 32'd7, 32'h0, 5'd9);
        for (int i = 0; i < 8; i++) step();
        flush = 1'b1;
        in_op = OP_ADD; in_reg1 = 32'd1; in_reg2 = 32'd1; in_valid = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("flush_never_valid", 64'(seen), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        $display("txn div flushed busy=%0b seen_valid=%0b", busy, seen);

        // Asynchronous reset in the middle of a multiply
        issue(OP_MUL, 32'h0, 32'd3, 32'd5, 32'h0, 5'd9);
        for (int i = 0; i < 5; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_rd_data", 64'(out_rd_data), 64'd0);
        chk("arst_target", 64'(jump_target), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid || busy) seen = 1'b1;
        end
        chk("arst_aborted", 64'(seen), 64'd0);
        $display("txn mul reset aborted seen=%0b", seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
